// File: rtl/match_mon_pkg.sv
// Shared definitions for the match event monitor: gap FSM encoding and default parameters.
package match_mon_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } gap_state_e;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_GAP_W  = 8;
  localparam int DEF_WIN    = 32;
  localparam int DEF_THRESH = 3;

endpackage

// File: rtl/match_event_monitor_if.sv
// Bundle between the sequence detector side and the match event monitor.
// Handshake: there is no valid/ready. det_in is a plain pulse where every high cycle is one
// match event with no backpressure. clr is a level sampled each clock and takes priority
// over det_in. All monitor outputs are registered and change only on the rising clock edge.
interface match_event_monitor_if #(
  parameter int CNT_W = match_mon_pkg::DEF_CNT_W,
  parameter int GAP_W = match_mon_pkg::DEF_GAP_W
);
  logic                    det_in;
  logic                    clr;
  logic [CNT_W-1:0]        total_cnt;
  logic                    sat;
  logic [GAP_W-1:0]        gap;
  logic                    gap_vld;
  logic                    burst;
  match_mon_pkg::gap_state_e gap_state;

  modport master (
    output det_in, clr,
    input  total_cnt, sat, gap, gap_vld, burst, gap_state
  );

  modport slave (
    input  det_in, clr,
    output total_cnt, sat, gap, gap_vld, burst, gap_state
  );
endinterface

// File: rtl/match_event_monitor_win_burst_check.sv
// Fixed-window hit counter: raises a one-cycle burst pulse when a WIN-cycle window
// collects at least THRESH hits.
module win_burst_check
  import match_mon_pkg::*;
#(
  parameter int WIN    = DEF_WIN,
  parameter int THRESH = DEF_THRESH
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hit,
  output logic burst
);

  localparam int TMR_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int HIT_W = $clog2(WIN + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WIN - 1);
  localparam logic [HIT_W-1:0] HIT_MAX  = HIT_W'(WIN);
  localparam logic [HIT_W:0]   THRESH_V = (HIT_W + 1)'(THRESH);

  logic [TMR_W-1:0] win_tmr_q, win_tmr_d;
  logic [HIT_W-1:0] win_hits_q, win_hits_d;
  logic             burst_q, burst_d;
  logic [HIT_W:0]   hit_sum;

  always_comb begin
    // The closing cycle's own hit still counts toward this window.
    hit_sum    = {1'b0, win_hits_q} + {{HIT_W{1'b0}}, hit};
    win_tmr_d  = win_tmr_q + TMR_W'(1);
    win_hits_d = win_hits_q;
    burst_d    = 1'b0;
    if (win_tmr_q == TMR_LAST) begin
      win_tmr_d  = '0;
      win_hits_d = '0;
      burst_d    = (hit_sum >= THRESH_V);
    end else if (hit && (win_hits_q != HIT_MAX)) begin
      win_hits_d = win_hits_q + HIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      win_tmr_q  <= '0;
      win_hits_q <= '0;
      burst_q    <= 1'b0;
    end else begin
      win_tmr_q  <= win_tmr_d;
      win_hits_q <= win_hits_d;
      burst_q    <= burst_d;
    end
  end

  assign burst = burst_q;

endmodule

// File: rtl/match_event_monitor.sv
// Match stream statistics: saturating total count with sticky overflow flag, inter-match
// gap timer driven by a two-state FSM, and a windowed burst detector.
module match_event_monitor
  import match_mon_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int GAP_W  = DEF_GAP_W,
  parameter int WIN    = DEF_WIN,
  parameter int THRESH = DEF_THRESH
) (
  input  logic                  clk,
  input  logic                  rst,
  match_event_monitor_if.slave  mon_if
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [GAP_W-1:0] GAP_MAX = '1;

  logic             hit;
  logic [CNT_W-1:0] total_q, total_d;
  logic             sat_q, sat_d;
  gap_state_e       state_q, state_d;
  logic [GAP_W-1:0] gap_tmr_q, gap_tmr_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             gap_vld_q, gap_vld_d;
  logic             burst;

  // A match coinciding with clr is dropped.
  assign hit = mon_if.det_in & ~mon_if.clr;

  always_comb begin
    total_d = total_q;
    sat_d   = sat_q;
    if (hit) begin
      if (total_q == CNT_MAX) sat_d = 1'b1;
      else                    total_d = total_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_tmr_d = gap_tmr_q;
    gap_d     = gap_q;
    gap_vld_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d   = ST_TRACK;
          gap_tmr_d = GAP_W'(1);
        end
      end
      ST_TRACK: begin
        if (hit) begin
          gap_d     = gap_tmr_q;
          gap_vld_d = 1'b1;
          gap_tmr_d = GAP_W'(1);
        end else if (gap_tmr_q != GAP_MAX) begin
          gap_tmr_d = gap_tmr_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || mon_if.clr) begin
      total_q   <= '0;
      sat_q     <= 1'b0;
      state_q   <= ST_IDLE;
      gap_tmr_q <= '0;
      gap_q     <= '0;
      gap_vld_q <= 1'b0;
    end else begin
      total_q   <= total_d;
      sat_q     <= sat_d;
      state_q   <= state_d;
      gap_tmr_q <= gap_tmr_d;
      gap_q     <= gap_d;
      gap_vld_q <= gap_vld_d;
    end
  end

  win_burst_check #(
    .WIN    (WIN),
    .THRESH (THRESH)
  ) u_win (
    .clk   (clk),
    .rst   (rst),
    .clr   (mon_if.clr),
    .hit   (hit),
    .burst (burst)
  );

  assign mon_if.total_cnt = total_q;
  assign mon_if.sat       = sat_q;
  assign mon_if.gap       = gap_q;
  assign mon_if.gap_vld   = gap_vld_q;
  assign mon_if.burst     = burst;
  assign mon_if.gap_state = state_q;

endmodule

// File: tb/tb_match_event_monitor.sv
// Directed bench for match_event_monitor: a default-width instance and a narrow
// (CNT_W=3, GAP_W=4) instance receive the same match stream.
module tb_match_event_monitor;
  import match_mon_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  match_event_monitor_if #(.CNT_W(16), .GAP_W(8)) if_d ();
  match_event_monitor_if #(.CNT_W(3),  .GAP_W(4)) if_s ();

  match_event_monitor #(.CNT_W(16), .GAP_W(8), .WIN(32), .THRESH(3)) dut_d (
    .clk    (clk),
    .rst    (rst),
    .mon_if (if_d.slave)
  );

  match_event_monitor #(.CNT_W(3), .GAP_W(4), .WIN(32), .THRESH(3)) dut_s (
    .clk    (clk),
    .rst    (rst),
    .mon_if (if_s.slave)
  );

  int   checks = 0;
  int   errors = 0;
  int   phase = 0;
  logic exp_close = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, sample 1 ns later.
  task automatic cyc(input logic det, input logic clr_v);
    int   was;
    logic exp_b;
    if_d.det_in = det;
    if_s.det_in = det;
    if_d.clr    = clr_v;
    if_s.clr    = clr_v;
    @(posedge clk);
    #1;
    was   = phase;
    exp_b = !rst && !clr_v && (was == 31) && exp_close;
    if (rst || clr_v) phase = 0;
    else              phase = (phase + 1) % 32;
    check("burst_d", 32'(if_d.burst), 32'(exp_b));
    check("burst_s", 32'(if_s.burst), 32'(exp_b));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic hit_chk(input logic exp_vld, input int exp_gap_d, input int exp_gap_s);
    cyc(1'b1, 1'b0);
    check("gap_vld_d", 32'(if_d.gap_vld), 32'(exp_vld));
    check("gap_vld_s", 32'(if_s.gap_vld), 32'(exp_vld));
    if (exp_vld) begin
      check("gap_d", 32'(if_d.gap), exp_gap_d);
      check("gap_s", 32'(if_s.gap), exp_gap_s);
    end
  endtask

  task automatic chk_zero();
    check("zero_total_d", 32'(if_d.total_cnt), 0);
    check("zero_total_s", 32'(if_s.total_cnt), 0);
    check("zero_sat_d",   32'(if_d.sat), 0);
    check("zero_sat_s",   32'(if_s.sat), 0);
    check("zero_gap_d",   32'(if_d.gap), 0);
    check("zero_gap_s",   32'(if_s.gap), 0);
    check("zero_vld_d",   32'(if_d.gap_vld), 0);
    check("zero_vld_s",   32'(if_s.gap_vld), 0);
    check("zero_burst_d", 32'(if_d.burst), 0);
    check("zero_state_d", 32'(if_d.gap_state), 32'(ST_IDLE));
    check("zero_state_s", 32'(if_s.gap_state), 32'(ST_IDLE));
  endtask

  initial begin
    if_d.det_in = 1'b0;
    if_s.det_in = 1'b0;
    if_d.clr    = 1'b0;
    if_s.clr    = 1'b0;

    // Reset, then three quiet windows.
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    rst = 1'b0;
    chk_zero();
    exp_close = 1'b0;
    idle(96);
    check("idle_total_d", 32'(if_d.total_cnt), 0);
    check("idle_state_d", 32'(if_d.gap_state), 32'(ST_IDLE));

    // Overlapping 1010 stream: a match every second cycle for a full window (16 hits).
    exp_close = 1'b1;
    for (int i = 0; i < 32; i++) begin
      int n;
      cyc((i % 2) == 0, 1'b0);
      if ((i % 2) == 0) begin
        n = i / 2 + 1;
        check("str_total_d", 32'(if_d.total_cnt), n);
        check("str_total_s", 32'(if_s.total_cnt), (n > 7) ? 7 : n);
        check("str_sat_s",   32'(if_s.sat), 32'(n >= 8));
        check("str_vld_d",   32'(if_d.gap_vld), 32'(i > 0));
        if (i > 0) begin
          check("str_gap_d", 32'(if_d.gap), 2);
          check("str_gap_s", 32'(if_s.gap), 2);
        end
      end else begin
        check("str_novld_d", 32'(if_d.gap_vld), 0);
      end
    end
    check("str_end_total_d", 32'(if_d.total_cnt), 16);
    check("str_end_total_s", 32'(if_s.total_cnt), 7);
    check("str_end_sat_s",   32'(if_s.sat), 1);
    check("str_end_sat_d",   32'(if_d.sat), 0);

    // clr wipes counters, saturation flag and the FSM.
    cyc(1'b0, 1'b1);
    chk_zero();

    // Window with two hits: no burst.
    exp_close = 1'b0;
    idle(5);
    hit_chk(1'b0, 0, 0);
    check("w2_total_d", 32'(if_d.total_cnt), 1);
    check("w2_state_d", 32'(if_d.gap_state), 32'(ST_TRACK));
    check("w2_state_s", 32'(if_s.gap_state), 32'(ST_TRACK));
    idle(4);
    hit_chk(1'b1, 5, 5);
    idle(21);

    // Next window: hits at 3, 20 and on the closing cycle 31 -> burst.
    exp_close = 1'b1;
    idle(3);
    hit_chk(1'b1, 25, 15);
    idle(16);
    hit_chk(1'b1, 17, 15);
    idle(10);
    hit_chk(1'b1, 11, 11);
    check("w3_total_d", 32'(if_d.total_cnt), 5);
    check("w3_total_s", 32'(if_s.total_cnt), 5);

    // Back-to-back across the window boundary, then 20 idle cycles.
    exp_close = 1'b0;
    hit_chk(1'b1, 1, 1);
    idle(20);
    hit_chk(1'b1, 21, 15);

    // clr together with a match mid-window: match discarded, window aborted.
    cyc(1'b1, 1'b1);
    chk_zero();
    idle(3);
    hit_chk(1'b0, 0, 0);
    check("post_clr_total_d", 32'(if_d.total_cnt), 1);
    check("post_clr_total_s", 32'(if_s.total_cnt), 1);
    check("post_clr_state_d", 32'(if_d.gap_state), 32'(ST_TRACK));
    idle(28);
    check("final_total_d", 32'(if_d.total_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
